hrm_inbox: RTL and testbench

Input queue for the HRM CPU: buffers the values to be consumed by the INBOX instruction and presents the head value on `oData`, which drives the `iInbox` input of the accumulator register. The external world (testbench or host loader) pushes values on the write side. The control unit pops one value per INBOX instruction on the read side, using `oEmpty` to detect the end-of-program condition. The queue is first-word-fall-through, so the head value is already valid in the cycle the control unit asserts its read strobe.

---
 rtl/hrm_inbox_if.sv | 41 ++++
 rtl/hrm_inbox.sv | 118 +++++++++++
 tb/tb_hrm_inbox.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hrm_inbox_if.sv
// Bus between the HRM inbox queue and its users: host-side push strobe,
// control-unit pop strobe, and the queue status/head outputs.
interface hrm_inbox_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
);
    logic [WIDTH-1:0] iData;
    logic             iWr;
    logic             oFull;
    logic             iRd;
    logic [WIDTH-1:0] oData;
    logic             oEmpty;
    logic [AW:0]      oCount;
    logic             oOverflow;
    logic             oUnderflow;

    modport master (
        output iData,
        output iWr,
        output iRd,
        input  oFull,
        input  oData,
        input  oEmpty,
        input  oCount,
        input  oOverflow,
        input  oUnderflow
    );

    modport slave (
        input  iData,
        input  iWr,
        input  iRd,
        output oFull,
        output oData,
        output oEmpty,
        output oCount,
        output oOverflow,
        output oUnderflow
    );
endinterface

// File: rtl/hrm_inbox.sv
// First-word-fall-through input queue feeding the HRM accumulator's iInbox;
// head value is valid while the control unit's read strobe is high.
module hrm_inbox #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    hrm_inbox_if.slave bus
);

    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_d;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    wptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             empty_s;
    logic             full_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [WIDTH-1:0] data_s;

    // Status decode and accept decisions; a full queue may still take a write
    // when a read frees a slot in the same cycle.
    always_comb begin
        empty_s  = (count_q == '0);
        full_s   = (count_q == DEPTH_C);
        rd_acc_s = bus.iRd & ~empty_s;
        wr_acc_s = bus.iWr & (~full_s | rd_acc_s);
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (rd_acc_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        if (wr_acc_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (bus.iWr && full_s && !rd_acc_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (bus.iRd && empty_s) begin
            unf_d = 1'b1;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents survive reset since the pointers discard them.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wptr_q] <= bus.iData;
        end
    end

    // Head value, forced to zero when nothing is queued.
    always_comb begin
        data_s = '0;
        if (!empty_s) begin
            data_s = mem_q[rptr_q];
        end else begin
            data_s = '0;
        end
    end

    assign bus.oData      = data_s;
    assign bus.oEmpty     = empty_s;
    assign bus.oFull      = full_s;
    assign bus.oCount     = count_q;
    assign bus.oOverflow  = ovf_q;
    assign bus.oUnderflow = unf_q;

endmodule

// File: tb/tb_hrm_inbox.sv
// Directed self-checking bench for hrm_inbox (WIDTH=8, DEPTH=32).
module tb_hrm_inbox;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hrm_inbox_if #(.WIDTH(8), .DEPTH(32)) bus ();

    hrm_inbox #(.WIDTH(8), .DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive strobes across one rising edge, return at the next falling edge.
    task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
        bus.iWr   = wr;
        bus.iRd   = rd;
        bus.iData = d;
        @(posedge clk);
        @(negedge clk);
        bus.iWr = 1'b0;
        bus.iRd = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, {24'h0, bus.oData}, {24'h0, exp});
        cyc(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.iWr   = 1'b0;
        bus.iRd   = 1'b0;
        bus.iData = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_empty", 32'(bus.oEmpty), 32'd1);
        check("rst_full",  32'(bus.oFull), 32'd0);
        check("rst_count", 32'(bus.oCount), 32'd0);
        check("rst_data",  32'(bus.oData), 32'h00);
        check("rst_ovf",   32'(bus.oOverflow), 32'd0);
        check("rst_unf",   32'(bus.oUnderflow), 32'd0);

        // Basic FWFT order with back-to-back pops
        cyc(1'b1, 1'b0, 8'h05);
        check("first_head", 32'(bus.oData), 32'h05);
        cyc(1'b1, 1'b0, 8'hFB);
        cyc(1'b1, 1'b0, 8'h00);
        check("count3", 32'(bus.oCount), 32'd3);
        pop_expect("pop_05", 8'h05);
        pop_expect("pop_FB", 8'hFB);
        pop_expect("pop_00", 8'h00);
        check("empty_after3", 32'(bus.oEmpty), 32'd1);
        check("unf_still0",   32'(bus.oUnderflow), 32'd0);
        check("data0_empty",  32'(bus.oData), 32'h00);

        // Fill, overflow, drain
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 8'(i));
        check("fill_full",  32'(bus.oFull), 32'd1);
        check("fill_count", 32'(bus.oCount), 32'd32);
        check("fill_ovf0",  32'(bus.oOverflow), 32'd0);
        cyc(1'b1, 1'b0, 8'hAA);
        check("ovf_set",    32'(bus.oOverflow), 32'd1);
        check("ovf_count",  32'(bus.oCount), 32'd32);
        for (int i = 0; i < 32; i++) pop_expect($sformatf("drain_%0d", i), 8'(i));
        check("drain_empty", 32'(bus.oEmpty), 32'd1);
        check("drain_noAA",  32'(bus.oData), 32'h00);

        // Full with simultaneous push and pop
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 8'(i));
        check("rw_head0", 32'(bus.oData), 32'h00);
        cyc(1'b1, 1'b1, 8'h77);
        check("rw_count", 32'(bus.oCount), 32'd32);
        check("rw_full",  32'(bus.oFull), 32'd1);
        for (int i = 1; i < 32; i++) pop_expect($sformatf("rw_drain_%0d", i), 8'(i));
        pop_expect("rw_last77", 8'h77);
        check("rw_empty", 32'(bus.oEmpty), 32'd1);

        // Empty with simultaneous push and pop
        check("unf_pre", 32'(bus.oUnderflow), 32'd0);
        cyc(1'b1, 1'b1, 8'h42);
        check("unf_set",   32'(bus.oUnderflow), 32'd1);
        check("unf_count", 32'(bus.oCount), 32'd1);
        pop_expect("unf_data42", 8'h42);

        // Asynchronous reset mid-operation
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(bus.oEmpty), 32'd1);
        check("arst_count", 32'(bus.oCount), 32'd0);
        check("arst_data",  32'(bus.oData), 32'h00);
        check("arst_ovf",   32'(bus.oOverflow), 32'd0);
        check("arst_unf",   32'(bus.oUnderflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 1'b0, 8'h11);
        pop_expect("post_rst_11", 8'h11);
        check("post_rst_empty", 32'(bus.oEmpty), 32'd1);

        // Pointer wrap: 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h80 + i));
            pop_expect($sformatf("wrap_%0d", i), 8'(8'h80 + i));
        end
        check("wrap_empty", 32'(bus.oEmpty), 32'd1);
        check("wrap_unf",   32'(bus.oUnderflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
